// File: rtl/cfg_arb_pkg.sv
// cfg_arb_pkg: shared types and constants for the cfg bus arbiter
// Command storage is ARB_ADDR_W/ARB_DATA_W wide; instances use CFG_*_WIDTH <= 32.
package cfg_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} arb_state_e;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam logic [31:0] CFG_TIMEOUT_DATA = 32'hDEAD_BEEF;
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wr_data;
    logic                  is_rd;
  } arb_cmd_s;
endpackage

// File: rtl/cfg_bus_arb_rr_pick.sv
// rr_pick: combinational round-robin picker
// Ports: req (per-master request), last_gnt (previous grant) -> pick (next index), vld (any request).
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic [IW-1:0] pick,
  output logic          vld
);
  logic [IW-1:0] idx;
  // Scan from the farthest candidate to the nearest, so the one right after last_gnt wins.
  always_comb begin
    pick = '0;
    idx = '0;
    vld = |req;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last_gnt) + k) % N);
      if (req[idx]) pick = idx;
    end
  end
endmodule

// File: rtl/cfg_bus_arb.sv
// cfg_bus_arb: round-robin arbiter sharing one cfg register bus between NUM_REQ masters
// Ports: i_axi_clk/i_axi_rst (async, active-high); s_cfg_* upstream per-master side
// (wr_en/rd_en/addr/wr_data in, busy/rd_vld/rd_data out); m_cfg_* downstream slave side.
// Optional macro CFG_ARB_TIMEOUT_EN adds a RD_TIMEOUT read watchdog and the o_rd_timeout port.
module cfg_bus_arb
  import cfg_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int CFG_ADDR_WIDTH = 32,
  parameter int CFG_DATA_WIDTH = 32,
  parameter int RD_TIMEOUT     = 1024
) (
  input  logic                                i_axi_clk,
  input  logic                                i_axi_rst,
`ifdef CFG_ARB_TIMEOUT_EN
  output logic                                o_rd_timeout,
`endif
  input  logic [NUM_REQ-1:0]                  s_cfg_wr_en,
  input  logic [NUM_REQ-1:0]                  s_cfg_rd_en,
  input  logic [NUM_REQ*CFG_ADDR_WIDTH-1:0]   s_cfg_addr,
  input  logic [NUM_REQ*CFG_DATA_WIDTH-1:0]   s_cfg_wr_data,
  output logic [NUM_REQ-1:0]                  s_cfg_busy,
  output logic [NUM_REQ-1:0]                  s_cfg_rd_vld,
  output logic [CFG_DATA_WIDTH-1:0]           s_cfg_rd_data,
  output logic                                m_cfg_wr_en,
  output logic                                m_cfg_rd_en,
  output logic [CFG_ADDR_WIDTH-1:0]           m_cfg_addr,
  output logic [CFG_DATA_WIDTH-1:0]           m_cfg_wr_data,
  input  logic                                m_cfg_rd_vld,
  input  logic [CFG_DATA_WIDTH-1:0]           m_cfg_rd_data,
  input  logic                                m_cfg_busy
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_e state_q, state_d;
  arb_cmd_s cmd_q;
  logic [IW-1:0] gnt_q, last_q, pick;
  logic vld, accept, deliver, tmo;
  logic [NUM_REQ-1:0] rd_vld_q;
  logic [CFG_DATA_WIDTH-1:0] rd_data_q;
  logic [CFG_ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [CFG_DATA_WIDTH-1:0] data_a [NUM_REQ];
`ifdef CFG_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
`endif
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = s_cfg_addr[i*CFG_ADDR_WIDTH +: CFG_ADDR_WIDTH];
    assign data_a[i] = s_cfg_wr_data[i*CFG_DATA_WIDTH +: CFG_DATA_WIDTH];
  end
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req      (s_cfg_wr_en | s_cfg_rd_en),
    .last_gnt (last_q),
    .pick     (pick),
    .vld      (vld)
  );
  assign accept = state_q == IDLE && vld;
  always_comb begin
    s_cfg_busy = '1;
    if (accept) s_cfg_busy[pick] = 1'b0;
  end
  // Enables follow the state register, so an async reset drops them at once.
  assign m_cfg_wr_en   = state_q == ISSUE && !cmd_q.is_rd;
  assign m_cfg_rd_en   = state_q == ISSUE && cmd_q.is_rd;
  assign m_cfg_addr    = CFG_ADDR_WIDTH'(cmd_q.addr);
  assign m_cfg_wr_data = CFG_DATA_WIDTH'(cmd_q.wr_data);
  assign s_cfg_rd_vld  = rd_vld_q;
  assign s_cfg_rd_data = rd_data_q;
  always_comb begin
    state_d = state_q;
    deliver = 1'b0;
    tmo = 1'b0;
    case (state_q)
      IDLE: state_d = vld ? ISSUE : IDLE;
      ISSUE:
        if (!m_cfg_busy) begin
          deliver = cmd_q.is_rd && m_cfg_rd_vld;
          state_d = (cmd_q.is_rd && !m_cfg_rd_vld) ? RD_WAIT : IDLE;
        end
      RD_WAIT: begin
        deliver = m_cfg_rd_vld;
`ifdef CFG_ARB_TIMEOUT_EN
        tmo = !m_cfg_rd_vld && cnt_q == 16'(RD_TIMEOUT - 1);
`endif
        state_d = (deliver || tmo) ? IDLE : RD_WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      state_q <= IDLE;
      cmd_q <= '0;
      gnt_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      rd_vld_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      rd_vld_q <= '0;
      if (accept) begin
        // Write wins when both enables are high; the read stays pending upstream.
        cmd_q <= '{addr: ARB_ADDR_W'(addr_a[pick]), wr_data: ARB_DATA_W'(data_a[pick]), is_rd: !s_cfg_wr_en[pick]};
        gnt_q <= pick;
        last_q <= pick;
      end
      if (deliver || tmo) begin
        rd_vld_q[gnt_q] <= 1'b1;
        rd_data_q <= tmo ? CFG_DATA_WIDTH'(CFG_TIMEOUT_DATA) : m_cfg_rd_data;
      end
    end
  end
`ifdef CFG_ARB_TIMEOUT_EN
  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      cnt_q <= '0;
      o_rd_timeout <= 1'b0;
    end else begin
      cnt_q <= (state_q == RD_WAIT) ? cnt_q + 16'd1 : '0;
      o_rd_timeout <= tmo;
    end
  end
`endif
endmodule

// File: tb/tb_cfg_bus_arb.sv
// tb_cfg_bus_arb: self-checking bench for cfg_bus_arb (NUM_REQ=2)
module tb_cfg_bus_arb;
  logic i_axi_clk = 1'b0;
  logic i_axi_rst = 1'b1;
  logic [1:0] s_cfg_wr_en = '0, s_cfg_rd_en = '0;
  logic [63:0] s_cfg_addr = {32'h20, 32'h10};
  logic [63:0] s_cfg_wr_data = {32'hB0B0_0002, 32'hA5A5_0001};
  logic [1:0] s_cfg_busy, s_cfg_rd_vld;
  logic [31:0] s_cfg_rd_data, m_cfg_addr, m_cfg_wr_data;
  logic m_cfg_wr_en, m_cfg_rd_en;
  logic m_cfg_rd_vld = 1'b0, m_cfg_busy = 1'b0;
  logic [31:0] m_cfg_rd_data = '0;
`ifdef CFG_ARB_TIMEOUT_EN
  logic o_rd_timeout;
`endif
  always #5 i_axi_clk = ~i_axi_clk;
  cfg_bus_arb #(.NUM_REQ(2), .CFG_ADDR_WIDTH(32), .CFG_DATA_WIDTH(32), .RD_TIMEOUT(8)) dut (
    .i_axi_clk     (i_axi_clk),
    .i_axi_rst     (i_axi_rst),
`ifdef CFG_ARB_TIMEOUT_EN
    .o_rd_timeout  (o_rd_timeout),
`endif
    .s_cfg_wr_en   (s_cfg_wr_en),
    .s_cfg_rd_en   (s_cfg_rd_en),
    .s_cfg_addr    (s_cfg_addr),
    .s_cfg_wr_data (s_cfg_wr_data),
    .s_cfg_busy    (s_cfg_busy),
    .s_cfg_rd_vld  (s_cfg_rd_vld),
    .s_cfg_rd_data (s_cfg_rd_data),
    .m_cfg_wr_en   (m_cfg_wr_en),
    .m_cfg_rd_en   (m_cfg_rd_en),
    .m_cfg_addr    (m_cfg_addr),
    .m_cfg_wr_data (m_cfg_wr_data),
    .m_cfg_rd_vld  (m_cfg_rd_vld),
    .m_cfg_rd_data (m_cfg_rd_data),
    .m_cfg_busy    (m_cfg_busy)
  );
  typedef struct {
    logic [1:0] wr, rd;
    logic mb, mv;
    logic [31:0] md;
    logic [1:0] bz;
    logic mw, mr;
    logic [31:0] ma, mwd;
    logic [1:0] rv;
    logic [31:0] rdd;
  } vec_t;
  vec_t tv[$];
  int total = 0, bad = 0, pops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;
  bit sb_on = 0;
  localparam logic [31:0] A = 32'hA5A5_0001, B = 32'hB0B0_0002;
  function automatic void add(input logic [1:0] wr, rd, input logic mb, mv, input logic [31:0] md,
                              input logic [1:0] bz, input logic mw, mr, input logic [31:0] ma, mwd,
                              input logic [1:0] rv, input logic [31:0] rdd);
    tv.push_back('{wr, rd, mb, mv, md, bz, mw, mr, ma, mwd, rv, rdd});
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge i_axi_clk);
    #1;
  endtask
  always @(negedge i_axi_clk)
    if (sb_on && m_cfg_wr_en && !m_cfg_busy) begin
      total++;
      pops++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra actual=%h required=none", m_cfg_addr);
      end else begin
        sb_e = exp_q.pop_front();
        if (m_cfg_addr !== sb_e) begin
          bad++;
          $display("FAIL sb_addr actual=%h required=%h", m_cfg_addr, sb_e);
        end
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    add(2'b01, 2'b00, 0, 0, 0,            2'b10, 0, 0, 32'h0,  32'h0, 2'b00, 32'h0);
    add(2'b00, 2'b00, 0, 0, 0,            2'b11, 1, 0, 32'h10, A,     2'b00, 32'h0);
    add(2'b00, 2'b10, 0, 0, 0,            2'b01, 0, 0, 32'h10, A,     2'b00, 32'h0);
    add(2'b00, 2'b00, 1, 0, 0,            2'b11, 0, 1, 32'h20, B,     2'b00, 32'h0);
    add(2'b00, 2'b00, 1, 0, 0,            2'b11, 0, 1, 32'h20, B,     2'b00, 32'h0);
    add(2'b00, 2'b00, 1, 0, 0,            2'b11, 0, 1, 32'h20, B,     2'b00, 32'h0);
    add(2'b00, 2'b00, 0, 0, 0,            2'b11, 0, 1, 32'h20, B,     2'b00, 32'h0);
    add(2'b00, 2'b00, 0, 0, 0,            2'b11, 0, 0, 32'h20, B,     2'b00, 32'h0);
    add(2'b00, 2'b00, 0, 1, 32'h1234_5678, 2'b11, 0, 0, 32'h20, B,    2'b00, 32'h0);
    add(2'b00, 2'b00, 0, 0, 0,            2'b11, 0, 0, 32'h20, B,     2'b10, 32'h1234_5678);
    add(2'b00, 2'b01, 0, 0, 0,            2'b10, 0, 0, 32'h20, B,     2'b00, 32'h1234_5678);
    add(2'b00, 2'b00, 0, 1, 32'hCAFE_0001, 2'b11, 0, 1, 32'h10, A,    2'b00, 32'h1234_5678);
    add(2'b10, 2'b00, 0, 0, 0,            2'b01, 0, 0, 32'h10, A,     2'b01, 32'hCAFE_0001);
    add(2'b00, 2'b00, 0, 0, 0,            2'b11, 1, 0, 32'h20, B,     2'b00, 32'hCAFE_0001);
    add(2'b01, 2'b01, 0, 0, 0,            2'b10, 0, 0, 32'h20, B,     2'b00, 32'hCAFE_0001);
    add(2'b00, 2'b01, 0, 0, 0,            2'b11, 1, 0, 32'h10, A,     2'b00, 32'hCAFE_0001);
    add(2'b00, 2'b01, 0, 0, 0,            2'b10, 0, 0, 32'h10, A,     2'b00, 32'hCAFE_0001);
    add(2'b00, 2'b00, 0, 0, 0,            2'b11, 0, 1, 32'h10, A,     2'b00, 32'hCAFE_0001);
    add(2'b00, 2'b00, 0, 1, 32'h0BAD_0002, 2'b11, 0, 0, 32'h10, A,    2'b00, 32'hCAFE_0001);
    add(2'b00, 2'b00, 0, 0, 0,            2'b11, 0, 0, 32'h10, A,     2'b01, 32'h0BAD_0002);
    add(2'b00, 2'b00, 0, 1, 32'h99,       2'b11, 0, 0, 32'h10, A,     2'b00, 32'h0BAD_0002);
    add(2'b00, 2'b00, 0, 0, 0,            2'b11, 0, 0, 32'h10, A,     2'b00, 32'h0BAD_0002);
    repeat (2) cyc();
    chk("reset_state", 128'({s_cfg_busy, m_cfg_wr_en, m_cfg_rd_en, m_cfg_addr, m_cfg_wr_data, s_cfg_rd_vld, s_cfg_rd_data}),
        128'({2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0}));
    i_axi_rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      s_cfg_wr_en = tv[i].wr;
      s_cfg_rd_en = tv[i].rd;
      m_cfg_busy = tv[i].mb;
      m_cfg_rd_vld = tv[i].mv;
      m_cfg_rd_data = tv[i].md;
      #4;
      chk($sformatf("row%0d", i),
          128'({s_cfg_busy, m_cfg_wr_en, m_cfg_rd_en, m_cfg_addr, m_cfg_wr_data, s_cfg_rd_vld, s_cfg_rd_data}),
          128'({tv[i].bz, tv[i].mw, tv[i].mr, tv[i].ma, tv[i].mwd, tv[i].rv, tv[i].rdd}));
      cyc();
    end
    {s_cfg_wr_en, s_cfg_rd_en, m_cfg_busy, m_cfg_rd_vld} = '0;
    s_cfg_addr = {32'h200, 32'h100};
    for (int i = 0; i < 6; i++) exp_q.push_back(i % 2 == 0 ? 32'h200 : 32'h100);
    sb_on = 1;
    s_cfg_wr_en = 2'b11;
    repeat (12) cyc();
    s_cfg_wr_en = 2'b00;
    repeat (2) cyc();
    sb_on = 0;
    chk("sb_pops", 128'(pops), 128'(6));
    chk("sb_left", 128'(exp_q.size()), 128'(0));
    s_cfg_rd_en = 2'b10;
    #4;
    chk("rst_rd_accept", 128'(s_cfg_busy), 128'(2'b01));
    cyc();
    s_cfg_rd_en = 2'b00;
    repeat (2) cyc();
    #2 i_axi_rst = 1'b1;
    #1;
    chk("async_reset", 128'({m_cfg_wr_en, m_cfg_rd_en, m_cfg_addr, m_cfg_wr_data, s_cfg_rd_vld, s_cfg_rd_data}), 128'(0));
    cyc();
    i_axi_rst = 1'b0;
    cyc();
    m_cfg_rd_vld = 1'b1;
    m_cfg_rd_data = 32'h77;
    cyc();
    m_cfg_rd_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk($sformatf("post_rst_idle%0d", i), 128'({s_cfg_rd_vld, s_cfg_rd_data}), 128'(0));
      cyc();
    end
`ifdef CFG_ARB_TIMEOUT_EN
    s_cfg_rd_en = 2'b01;
    #4;
    chk("tmo_accept", 128'(s_cfg_busy), 128'(2'b10));
    cyc();
    s_cfg_rd_en = 2'b00;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      #4;
      if (o_rd_timeout) n = i;
      else cyc();
    end
    chk("tmo_latency", 128'(n), 128'(10));
    chk("tmo_resp", 128'({s_cfg_rd_vld, s_cfg_rd_data}), 128'({2'b01, 32'hDEAD_BEEF}));
`else
    n = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cfg_bus_arb.md
Name: cfg_bus_arb

Overview:
- Round-robin arbiter sharing one cfg register bus (wr_en/rd_en/addr/wr_data, rd_vld/rd_data, busy) between NUM_REQ masters.
- Typical masters: the AXI-lite-to-cfg converter and internal sequencers such as a boot-time register loader.
- Sits between those masters and the cfg slave decode.
- Serializes accesses and routes each read response back to the master that issued it.

Parameters:
- NUM_REQ, 2: number of requesting masters, 2..8.
- CFG_ADDR_WIDTH, 32: cfg address width.
- CFG_DATA_WIDTH, 32: cfg data width.
- RD_TIMEOUT, 1024: cycles to wait for m_cfg_rd_vld. Used only with CFG_ARB_TIMEOUT_EN.

Ports:
- i_axi_clk  in  1  clock.
- i_axi_rst  in  1  reset, asynchronous, active-high.
- s_cfg_wr_en  in  NUM_REQ  per-master write request, held until accepted.
- s_cfg_rd_en  in  NUM_REQ  per-master read request, held until accepted.
- s_cfg_addr  in  NUM_REQ*CFG_ADDR_WIDTH  packed addresses, master i at slice i.
- s_cfg_wr_data  in  NUM_REQ*CFG_DATA_WIDTH  packed write data.
- s_cfg_busy  out  NUM_REQ  per-master busy. Request accepted in the cycle en=1 and busy=0.
- s_cfg_rd_vld  out  NUM_REQ  one-cycle read-return strobe to the issuing master.
- s_cfg_rd_data  out  CFG_DATA_WIDTH  read data, shared by all masters, qualified by s_cfg_rd_vld.
- m_cfg_wr_en  out  1  downstream write, held until m_cfg_busy=0.
- m_cfg_rd_en  out  1  downstream read, held until m_cfg_busy=0.
- m_cfg_addr  out  CFG_ADDR_WIDTH  downstream address.
- m_cfg_wr_data  out  CFG_DATA_WIDTH  downstream write data.
- m_cfg_rd_vld  in  1  downstream read-return strobe.
- m_cfg_rd_data  in  CFG_DATA_WIDTH  downstream read data.
- m_cfg_busy  in  1  downstream busy. A command completes in the first cycle en=1 and busy=0.
- o_rd_timeout  out  1  present only with CFG_ARB_TIMEOUT_EN.

Behaviour:
- Clock/reset: one clock, i_axi_clk. Reset i_axi_rst is asynchronous, active-high.
- Reset values:
  - State IDLE; last_gnt = NUM_REQ-1, so master 0 has first priority.
  - m_cfg_wr_en = m_cfg_rd_en = 0; m_cfg_addr = m_cfg_wr_data = 0.
  - s_cfg_rd_vld = 0; s_cfg_rd_data = 0; o_rd_timeout = 0.
- Request vector: req[i] = s_cfg_wr_en[i] | s_cfg_rd_en[i].
- Priority: round-robin, searching from last_gnt+1 with wrap at NUM_REQ-1 back to 0.
- s_cfg_busy[i] (combinational) = !(state==IDLE && req!=0 && pick==i). It is 1 for every master outside IDLE.
- IDLE:
  - If req!=0, accept master pick in cycle T.
  - Register addr, wr_data, type and gnt_idx; set last_gnt = pick; go ISSUE.
  - m_cfg_*_en rises at T+1.
  - If a master has both wr_en and rd_en high, the write wins. rd_en stays pending and is re-arbitrated later.
- ISSUE: hold the enable, addr and wr_data stable while m_cfg_busy=1. On m_cfg_busy=0, deassert the enable next cycle, then:
  - Write: go IDLE.
  - Read, m_cfg_rd_vld=0 in the same cycle: go RD_WAIT.
  - Read, m_cfg_rd_vld=1 in the same cycle: capture data and return as in RD_WAIT, then go IDLE.
- RD_WAIT: on m_cfg_rd_vld, register s_cfg_rd_data = m_cfg_rd_data and pulse s_cfg_rd_vld[gnt_idx] for one cycle; go IDLE.
- m_cfg_rd_vld outside a pending read is ignored.
- Minimum throughput, zero-wait slave: one accept every 2 cycles (accept T, issue T+1, IDLE T+2).
- Read return: s_cfg_rd_vld appears one cycle after m_cfg_rd_vld.
- Mid-operation reset: the in-flight command is aborted and the enables drop immediately. A later m_cfg_rd_vld is ignored.
- Starvation bound: with all masters requesting, each master waits at most NUM_REQ-1 grants.

Optional Feature:
- Macro: CFG_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit counter cleared on RD_WAIT entry, incremented each RD_WAIT cycle.
  - When it reaches RD_TIMEOUT: pulse s_cfg_rd_vld[gnt_idx] with s_cfg_rd_data = 32'hDEAD_BEEF truncated to CFG_DATA_WIDTH, pulse o_rd_timeout for one cycle, go IDLE.
  - A late m_cfg_rd_vld is dropped.
- Undefined: no counter, no o_rd_timeout port; RD_WAIT waits indefinitely.

Decomposition:
- Package cfg_arb_pkg holds:
  - Enum arb_state_e {IDLE, ISSUE, RD_WAIT} as logic [1:0].
  - Constant CFG_TIMEOUT_DATA = 32'hDEAD_BEEF.
  - Struct arb_cmd_s {addr, wr_data, is_rd}.
- Sub-module rr_pick (combinational): inputs req and last_gnt; outputs pick index and a valid flag.
- FSM, registers and routing stay in cfg_bus_arb.

Test Plan:
- NUM_REQ=2, master0 writes addr 0x10 / data 0xA5A5_0001, m_cfg_busy=0 → m_cfg_wr_en high exactly 1 cycle at T+1 with that addr/data; s_cfg_busy[0]=0 at T only.
- Both masters write continuously → grants alternate 0,1,0,1; m_cfg_addr sequence matches the interleave; no master is granted twice in a row.
- Master1 reads 0x20, m_cfg_busy=1 for 3 cycles, m_cfg_rd_vld with 0x1234_5678 two cycles after release → m_cfg_rd_en held 4 cycles; s_cfg_rd_vld[1] for 1 cycle with data 0x1234_5678; s_cfg_rd_vld[0] stays 0.
- m_cfg_rd_vld arrives in the same cycle m_cfg_busy drops → response delivered, FSM goes directly to IDLE, next request accepted the following cycle.
- i_axi_rst asserted during RD_WAIT, then m_cfg_rd_vld pulses → all outputs at reset values asynchronously; no s_cfg_rd_vld generated.
- With CFG_ARB_TIMEOUT_EN and RD_TIMEOUT=8, read with no m_cfg_rd_vld → after 8 RD_WAIT cycles o_rd_timeout=1 and s_cfg_rd_vld with data 0xDEAD_BEEF, then IDLE.
